// File: rtl/bp_fpga_mem_arbiter.sv
// rtl/bp_fpga_mem_arbiter.sv - round-robin arbiter sharing one memory port between host and BlackParrot
module bp_fpga_mem_arbiter #(
    parameter int addr_width_p = 64,
    parameter int data_width_p = 64,
    parameter int timeout_p    = 1024
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,

    input  logic                      req0_v_i,
    output logic                      req0_ready_o,
    input  logic                      req0_we_i,
    input  logic [addr_width_p-1:0]   req0_addr_i,
    input  logic [data_width_p-1:0]   req0_data_i,
    input  logic [data_width_p/8-1:0] req0_mask_i,
    output logic                      resp0_v_o,
    input  logic                      resp0_ready_i,
    output logic [data_width_p-1:0]   resp0_data_o,
    output logic                      resp0_err_o,

    input  logic                      req1_v_i,
    output logic                      req1_ready_o,
    input  logic                      req1_we_i,
    input  logic [addr_width_p-1:0]   req1_addr_i,
    input  logic [data_width_p-1:0]   req1_data_i,
    input  logic [data_width_p/8-1:0] req1_mask_i,
    output logic                      resp1_v_o,
    input  logic                      resp1_ready_i,
    output logic [data_width_p-1:0]   resp1_data_o,
    output logic                      resp1_err_o,

    output logic                      mem_req_v_o,
    input  logic                      mem_req_ready_i,
    output logic                      mem_req_we_o,
    output logic [addr_width_p-1:0]   mem_req_addr_o,
    output logic [data_width_p-1:0]   mem_req_data_o,
    output logic [data_width_p/8-1:0] mem_req_mask_o,
    output logic                      mem_req_src_o,
    input  logic                      mem_resp_v_i,
    output logic                      mem_resp_ready_o,
    input  logic [data_width_p-1:0]   mem_resp_data_i,

    output logic                      timeout_o,
    output logic [7:0]                stale_cnt_o
);

    localparam int cnt_width_lp = (timeout_p > 1) ? $clog2(timeout_p) : 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} state_e;

    state_e                      state_r, state_n;
    logic                        last_grant_r;
    logic                        grant;
    logic                        accept;
    logic                        resp_hs;
    logic                        timeout_hit;
    logic                        we_r;
    logic [addr_width_p-1:0]     addr_r;
    logic [data_width_p-1:0]     data_r;
    logic [data_width_p/8-1:0]   mask_r;
    logic                        src_r;
    logic [data_width_p-1:0]     resp_data_r;
    logic                        resp_err_r;
    logic                        timeout_r;
    logic [7:0]                  stale_cnt_r;
    logic [cnt_width_lp-1:0]     cnt_r;

    // Round-robin pick: a lone requester wins, a tie goes to whoever did not win last
    always_comb begin
        if (req0_v_i && req1_v_i) grant = ~last_grant_r;
        else                      grant = req1_v_i;
    end

    assign timeout_hit = (timeout_p != 0) && (state_r == WAIT) && !mem_resp_v_i
                         && (cnt_r == cnt_width_lp'(timeout_p - 1));

    // State register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_r <= IDLE;
        else            state_r <= state_n;
    end

    // Next state and handshake outputs; readies are held low while reset is asserted
    always_comb begin
        state_n          = state_r;
        req0_ready_o     = reset_n_i && (state_r == IDLE) && req0_v_i && !grant;
        req1_ready_o     = reset_n_i && (state_r == IDLE) && req1_v_i && grant;
        accept           = req0_ready_o || req1_ready_o;
        mem_req_v_o      = (state_r == SEND);
        mem_resp_ready_o = reset_n_i;
        resp0_v_o        = (state_r == RESP) && !src_r;
        resp1_v_o        = (state_r == RESP) && src_r;
        resp_hs          = (resp0_v_o && resp0_ready_i) || (resp1_v_o && resp1_ready_i);
        case (state_r)
            IDLE:    if (accept) state_n = SEND;
            SEND:    if (mem_req_ready_i) state_n = WAIT;
            WAIT:    if (mem_resp_v_i || timeout_hit) state_n = RESP;
            RESP:    if (resp_hs) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Request latch, response capture, timeout counter and stale-response accounting
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            last_grant_r <= 1'b1;
            we_r         <= 1'b0;
            addr_r       <= '0;
            data_r       <= '0;
            mask_r       <= '0;
            src_r        <= 1'b0;
            resp_data_r  <= '0;
            resp_err_r   <= 1'b0;
            timeout_r    <= 1'b0;
            stale_cnt_r  <= '0;
            cnt_r        <= '0;
        end else begin
            if (accept) begin
                we_r         <= grant ? req1_we_i   : req0_we_i;
                addr_r       <= grant ? req1_addr_i : req0_addr_i;
                data_r       <= grant ? req1_data_i : req0_data_i;
                mask_r       <= grant ? req1_mask_i : req0_mask_i;
                src_r        <= grant;
                last_grant_r <= grant;
            end
            if (state_r == SEND && mem_req_ready_i) cnt_r <= '0;
            else if (state_r == WAIT)               cnt_r <= cnt_r + cnt_width_lp'(1);
            if (state_r == WAIT) begin
                if (mem_resp_v_i) begin
                    resp_data_r <= we_r ? '0 : mem_resp_data_i;
                    resp_err_r  <= 1'b0;
                end else if (timeout_hit) begin
                    resp_data_r <= '1;
                    resp_err_r  <= 1'b1;
                    timeout_r   <= 1'b1;
                end
            end
            if (mem_resp_v_i && state_r != WAIT && stale_cnt_r != 8'hFF)
                stale_cnt_r <= stale_cnt_r + 8'd1;
        end
    end

    assign mem_req_we_o   = we_r;
    assign mem_req_addr_o = addr_r;
    assign mem_req_data_o = data_r;
    assign mem_req_mask_o = mask_r;
    assign mem_req_src_o  = src_r;
    assign resp0_data_o   = resp_data_r;
    assign resp1_data_o   = resp_data_r;
    assign resp0_err_o    = resp0_v_o && resp_err_r;
    assign resp1_err_o    = resp1_v_o && resp_err_r;
    assign timeout_o      = timeout_r;
    assign stale_cnt_o    = stale_cnt_r;

endmodule

// File: doc/bp_fpga_mem_arbiter.md
Name: bp_fpga_mem_arbiter

Overview:
- Shares the single FPGA memory port between two requesters: the FPGA host (requester 0) and BlackParrot (requester 1).
- Round-robin arbitration with one outstanding transaction at a time. The winning request is registered and forwarded to memory. The memory response is returned to the requester that issued it.
- A per-transaction timeout stops a hung memory from deadlocking host or BP. Sits between the host/BP memory-side adapters and the memory AXI bridge.

Parameters:
- addr_width_p, 64, request address width
- data_width_p, 64, data width; mask width is data_width_p/8
- timeout_p, 1024, cycles in WAIT before a synthetic error response; 0 disables the timeout

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- reqN_v_i (N=0,1)  in  1  request valid
- reqN_ready_o (N=0,1)  out  1  request accepted when v&ready
- reqN_we_i (N=0,1)  in  1  1=write, 0=read
- reqN_addr_i (N=0,1)  in  addr_width_p  byte address
- reqN_data_i (N=0,1)  in  data_width_p  write data
- reqN_mask_i (N=0,1)  in  data_width_p/8  write byte enables
- respN_v_o (N=0,1)  out  1  response valid
- respN_ready_i (N=0,1)  in  1  response consumed when v&ready
- respN_data_o (N=0,1)  out  data_width_p  read data; 0 for writes
- respN_err_o (N=0,1)  out  1  response is a timeout error
- mem_req_v_o  out  1  memory request valid
- mem_req_ready_i  in  1  memory accepts request
- mem_req_we_o / mem_req_addr_o / mem_req_data_o / mem_req_mask_o  out  1/addr/data/mask  forwarded request fields
- mem_req_src_o  out  1  index of the issuing requester
- mem_resp_v_i  in  1  memory response valid
- mem_resp_ready_o  out  1  arbiter accepts memory response
- mem_resp_data_i  in  data_width_p  response data
- timeout_o  out  1  sticky: at least one timeout since reset
- stale_cnt_o  out  8  saturating count of dropped late responses

Behaviour:
- **Reset.** Asynchronous assert, synchronous release.
  - State=IDLE; last_grant=1, so requester 0 wins first.
  - All _v_o, _ready_o, respN_err_o, timeout_o = 0; stale_cnt_o=0; data registers = 0.
- **FSM states:** IDLE, SEND, WAIT, RESP.
- **IDLE.**
  - grant = the only valid requester. If both are valid, grant = !last_grant.
  - reqN_ready_o = (state==IDLE) & reqN_v_i & (grant==N), combinational. At most one ready is high per cycle.
  - On accept: latch we/addr/data/mask/src, last_grant<=src, go to SEND.
- **SEND.**
  - mem_req_v_o=1 with the latched fields. Fields are held stable until mem_req_ready_i.
  - On handshake: clear the timeout counter, go to WAIT.
  - Minimum latency: accept at cycle T, mem_req_v_o at T+1.
- **WAIT.**
  - mem_resp_ready_o=1.
  - On mem_resp_v_i: latch data (forced to 0 if we), err=0, go to RESP.
  - Otherwise the counter increments. When counter==timeout_p-1 and no response arrives that cycle: data=all-ones, err=1, timeout_o<=1, go to RESP.
  - If a response and the timeout coincide, the response wins (err=0).
- **RESP.**
  - resp[src]_v_o=1 with the latched data/err. The other requester's resp_v_o=0.
  - On resp[src]_ready_i: go to IDLE.
  - New requests are not accepted until the cycle after IDLE is entered. Minimum request-to-request turnaround is 4 cycles.
- **Stale responses.**
  - mem_resp_ready_o=1 also in IDLE, RESP and SEND, so late responses after a timeout are drained.
  - Any mem_resp_v_i outside WAIT is dropped; stale_cnt_o increments and saturates at 255.
- **Constraints.**
  - mem_req_src_o is valid whenever mem_req_v_o=1.
  - Requesters may drop reqN_v_i while not accepted. The arbiter makes no assumption about request stability before acceptance.
- **Reset mid-operation.** Aborts any transaction and returns to IDLE. Pending memory responses arriving after reset are counted as stale.

Test Plan:
- Single read, req0 addr=0x80000000: mem_req_v_o at T+1 with src=0. Memory responds 0xDEADBEEF_CAFEF00D → resp0_v_o with that data, err=0; resp1_v_o stays 0.
- Both requesters valid continuously for 4 transactions: grant order 0,1,0,1. reqN_ready_o is never high for both in the same cycle.
- Write req1, mask=0x0F, data=0x1122334455667788: mem_req fields match exactly. resp1_data_o=0 and err=0 after the memory response.
- timeout_p=16, memory never responds: resp0 returns after 16 WAIT cycles with data=all-ones, err=1, timeout_o=1. A late mem_resp_v_i then gives stale_cnt_o=1 and no respN_v_o.
- mem_req_ready_i held low 10 cycles, resp0_ready_i held low 5 cycles: request fields and response data stay stable. Requester 1 is not granted until the cycle after resp0 handshakes.
- reset_n_i asserted in WAIT mid-transaction: all outputs go to 0 immediately and state=IDLE. After release, req0 wins first.
